// File: rtl/card_pkg.sv
// Shared deck constants, card field types and the deal FSM state type
// for the card-deal receive path.
package card_pkg;

    localparam int unsigned DECK_SIZE_DEF = 52;
    localparam int unsigned RANKS_DEF     = 13;
    localparam int unsigned SUITS_DEF     = 4;
    localparam int unsigned NUM_CARDS_DEF = 9;

    typedef logic [5:0] card_idx_t;
    typedef logic [3:0] card_rank_t;
    typedef logic [1:0] card_suit_t;
    typedef logic [3:0] card_cnt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } deal_state_t;

endpackage

// File: rtl/card_stream_checker_if.sv
// Dealer-to-checker card stream plus the checker's decode/status outputs.
// master = dealer/consumer side, slave = checker side.
interface card_stream_checker_if #(
    parameter int unsigned DECK_SIZE = card_pkg::DECK_SIZE_DEF
);
    import card_pkg::*;

    logic                 start;
    logic                 card_valid;
    card_idx_t            card_num;
    logic                 card_ready;
    logic                 dec_valid;
    card_rank_t           dec_rank;
    card_suit_t           dec_suit;
    card_cnt_t            dec_index;
    logic                 dup_err;
    logic                 range_err;
    card_cnt_t            card_count;
    logic                 deal_done;
    logic [DECK_SIZE-1:0] used_mask;

    modport master (
        output start, card_valid, card_num,
        input  card_ready, dec_valid, dec_rank, dec_suit, dec_index,
               dup_err, range_err, card_count, deal_done, used_mask
    );

    modport slave (
        input  start, card_valid, card_num,
        output card_ready, dec_valid, dec_rank, dec_suit, dec_index,
               dup_err, range_err, card_count, deal_done, used_mask
    );

endinterface

// File: rtl/card_decode.sv
// Combinational card index -> rank/suit split without a divider; also flags
// whether the index lies inside the deck.
module card_decode
    import card_pkg::*;
#(
    parameter int unsigned DECK_SIZE = DECK_SIZE_DEF,
    parameter int unsigned RANKS     = RANKS_DEF
) (
    input  card_idx_t  idx_i,
    output card_rank_t rank_o,
    output card_suit_t suit_o,
    output logic       valid_idx_o
);

    logic [31:0] idx_w;

    always_comb begin
        idx_w       = 32'(idx_i);
        valid_idx_o = (idx_w < DECK_SIZE);
        // Suit boundaries are multiples of RANKS; rank is the remainder after one subtract.
        if (idx_w >= 3 * RANKS) begin
            suit_o = 2'd3;
            rank_o = card_rank_t'(idx_w - 3 * RANKS);
        end else if (idx_w >= 2 * RANKS) begin
            suit_o = 2'd2;
            rank_o = card_rank_t'(idx_w - 2 * RANKS);
        end else if (idx_w >= RANKS) begin
            suit_o = 2'd1;
            rank_o = card_rank_t'(idx_w - RANKS);
        end else begin
            suit_o = 2'd0;
            rank_o = card_rank_t'(idx_w);
        end
    end

endmodule

// File: rtl/card_stream_checker.sv
// Receives dealt cards over valid/ready, rejects out-of-range and repeated
// cards, decodes accepted ones and flags completion of a NUM_CARDS deal.
module card_stream_checker
    import card_pkg::*;
#(
    parameter int unsigned NUM_CARDS = NUM_CARDS_DEF,
    parameter int unsigned DECK_SIZE = DECK_SIZE_DEF,
    parameter int unsigned RANKS     = RANKS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    card_stream_checker_if.slave   bus
);

    deal_state_t          state_q;
    logic [DECK_SIZE-1:0] used_mask_q;
    logic [DECK_SIZE-1:0] used_mask_d;
    card_cnt_t            count_q;
    card_cnt_t            count_d;
    logic                 dec_valid_q;
    card_rank_t           dec_rank_q;
    card_suit_t           dec_suit_q;
    card_cnt_t            dec_index_q;
    logic                 dup_err_q;
    logic                 range_err_q;
    logic                 deal_done_q;

    card_rank_t           cur_rank;
    card_suit_t           cur_suit;
    logic                 idx_ok;
    logic                 card_ready;
    logic                 xfer;
    logic                 is_dup;
    logic                 last_card;
    logic [63:0]          mask_ext;
    logic [63:0]          card_onehot;

    card_decode #(
        .DECK_SIZE (DECK_SIZE),
        .RANKS     (RANKS)
    ) u_decode (
        .idx_i       (bus.card_num),
        .rank_o      (cur_rank),
        .suit_o      (cur_suit),
        .valid_idx_o (idx_ok)
    );

    always_comb begin
        card_ready  = (state_q == COLLECT) && !bus.start;
        xfer        = bus.card_valid && card_ready;
        // Pad the mask to the full 6-bit index space so any card_num can be looked up safely.
        mask_ext    = '0;
        mask_ext[DECK_SIZE-1:0] = used_mask_q;
        is_dup      = idx_ok && mask_ext[bus.card_num];
        card_onehot = 64'd1 << bus.card_num;
        used_mask_d = used_mask_q | card_onehot[DECK_SIZE-1:0];
        count_d     = (32'(count_q) < NUM_CARDS) ? count_q + 4'd1 : count_q;
        last_card   = (32'(count_d) == NUM_CARDS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            used_mask_q <= '0;
            count_q     <= '0;
            dec_valid_q <= 1'b0;
            dec_rank_q  <= '0;
            dec_suit_q  <= '0;
            dec_index_q <= '0;
            dup_err_q   <= 1'b0;
            range_err_q <= 1'b0;
            deal_done_q <= 1'b0;
        end else begin
            dec_valid_q <= 1'b0;
            dup_err_q   <= 1'b0;
            range_err_q <= 1'b0;
            if (bus.start) begin
                state_q     <= COLLECT;
                used_mask_q <= '0;
                count_q     <= '0;
                deal_done_q <= 1'b0;
            end else if (xfer) begin
                if (!idx_ok) begin
                    range_err_q <= 1'b1;
                end else if (is_dup) begin
                    dup_err_q <= 1'b1;
                end else begin
                    used_mask_q <= used_mask_d;
                    count_q     <= count_d;
                    dec_valid_q <= 1'b1;
                    dec_rank_q  <= cur_rank;
                    dec_suit_q  <= cur_suit;
                    dec_index_q <= count_q;
                    if (last_card) begin
                        state_q     <= DONE;
                        deal_done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.card_ready = card_ready;
    assign bus.dec_valid  = dec_valid_q;
    assign bus.dec_rank   = dec_rank_q;
    assign bus.dec_suit   = dec_suit_q;
    assign bus.dec_index  = dec_index_q;
    assign bus.dup_err    = dup_err_q;
    assign bus.range_err  = range_err_q;
    assign bus.card_count = count_q;
    assign bus.deal_done  = deal_done_q;
    assign bus.used_mask  = used_mask_q;

endmodule

// File: tb/tb_card_stream_checker.sv
// Directed and randomized checks of card_stream_checker against a queue-based
// model of the deal (list of dealt cards, rank/suit by % and /).
module tb_card_stream_checker;

    localparam int NUM  = 9;
    localparam int DECK = 52;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    card_stream_checker_if #(.DECK_SIZE(DECK)) bus ();

    card_stream_checker #(
        .NUM_CARDS (NUM),
        .DECK_SIZE (DECK),
        .RANKS     (13)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    int dealt[$];
    bit in_deal;
    int m_rank, m_suit, m_idx;
    bit m_dv, m_dup, m_rng;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_mask();
        logic [63:0] m;
        m = '0;
        foreach (dealt[i]) m[dealt[i]] = 1'b1;
        return m;
    endfunction

    function automatic bit model_has(input int n);
        foreach (dealt[i]) if (dealt[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        dealt.delete();
        in_deal = 1'b0;
        m_rank = 0; m_suit = 0; m_idx = 0;
        m_dv = 0; m_dup = 0; m_rng = 0;
    endtask

    task automatic check_outputs();
        chk("dec_valid",  64'(bus.dec_valid),  64'(m_dv));
        chk("dup_err",    64'(bus.dup_err),    64'(m_dup));
        chk("range_err",  64'(bus.range_err),  64'(m_rng));
        chk("card_count", 64'(bus.card_count), 64'(dealt.size()));
        chk("deal_done",  64'(bus.deal_done),  64'(in_deal && dealt.size() == NUM));
        chk("used_mask",  64'(bus.used_mask),  model_mask());
        chk("dec_rank",   64'(bus.dec_rank),   64'(m_rank));
        chk("dec_suit",   64'(bus.dec_suit),   64'(m_suit));
        chk("dec_index",  64'(bus.dec_index),  64'(m_idx));
    endtask

    // Drive one cycle of inputs, check ready, advance one edge, check registered outputs.
    task automatic cycle(input bit st, input bit v, input int n);
        bit rdy;
        bus.start      = st;
        bus.card_valid = v;
        bus.card_num   = 6'(n);
        #1;
        rdy = in_deal && (dealt.size() < NUM) && !st;
        chk("card_ready", 64'(bus.card_ready), 64'(rdy));
        m_dv = 0; m_dup = 0; m_rng = 0;
        if (st) begin
            dealt.delete();
            in_deal = 1'b1;
        end else if (v && rdy) begin
            if (n >= DECK) m_rng = 1;
            else if (model_has(n)) m_dup = 1;
            else begin
                m_dv   = 1;
                m_rank = n % 13;
                m_suit = n / 13;
                m_idx  = dealt.size();
                dealt.push_back(n);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        int deal1[9];
        int r, n;
        bit st, v;
        logic [63:0] exp_mask;

        deal1 = '{0, 13, 26, 39, 51, 12, 1, 2, 3};
        bus.start = 1'b0;
        bus.card_valid = 1'b0;
        bus.card_num = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_ready", 64'(bus.card_ready), 64'd0);
        check_outputs();

        // Full deal with suit boundaries and the top card.
        cycle(1, 0, 0);
        foreach (deal1[i]) begin
            cycle(0, 1, deal1[i]);
            if (deal1[i] == 51) begin
                chk("rank51", 64'(bus.dec_rank), 64'd12);
                chk("suit51", 64'(bus.dec_suit), 64'd3);
            end
            if (deal1[i] == 13) begin
                chk("rank13", 64'(bus.dec_rank), 64'd0);
                chk("suit13", 64'(bus.dec_suit), 64'd1);
            end
        end
        exp_mask = '0;
        foreach (deal1[i]) exp_mask[deal1[i]] = 1'b1;
        chk("deal_done9", 64'(bus.deal_done), 64'd1);
        chk("mask9", 64'(bus.used_mask), exp_mask);

        // DONE ignores offered cards.
        repeat (3) cycle(0, 1, 7);
        chk("count_hold", 64'(bus.card_count), 64'd9);
        cycle(1, 0, 0);
        chk("count_clr", 64'(bus.card_count), 64'd0);
        chk("mask_clr", 64'(bus.used_mask), 64'd0);

        // Back-to-back duplicate.
        cycle(0, 1, 5);
        cycle(0, 1, 5);
        chk("dup_pulse", 64'(bus.dup_err), 64'd1);
        cycle(0, 1, 6);
        chk("idx_after_dup", 64'(bus.dec_index), 64'd1);
        chk("count_after_dup", 64'(bus.card_count), 64'd2);

        // Range errors.
        cycle(1, 0, 0);
        cycle(0, 1, 52);
        chk("range52", 64'(bus.range_err), 64'd1);
        cycle(0, 1, 63);
        chk("range63", 64'(bus.range_err), 64'd1);
        chk("range_mask", 64'(bus.used_mask), 64'd0);

        // Start beats a same-cycle card.
        cycle(1, 0, 0);
        cycle(0, 1, 10); cycle(0, 1, 11); cycle(0, 1, 12); cycle(0, 1, 14);
        cycle(1, 1, 20);
        chk("restart_count", 64'(bus.card_count), 64'd0);
        cycle(0, 1, 20);
        chk("restart_idx", 64'(bus.dec_index), 64'd0);

        // Asynchronous reset between edges, right after an accept pulse.
        cycle(1, 0, 0);
        cycle(0, 1, 30); cycle(0, 1, 31); cycle(0, 1, 32);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_ready", 64'(bus.card_ready), 64'd0);
        check_outputs();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        cycle(0, 1, 33);
        cycle(1, 0, 0);

        // Randomized traffic with duplicates, out-of-range cards and restarts.
        repeat (400) begin
            st = ($urandom_range(0, 24) == 0);
            v  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            if (r == 0) n = $urandom_range(52, 63);
            else if (r < 3 && dealt.size() > 0) n = dealt[$urandom_range(0, dealt.size() - 1)];
            else n = $urandom_range(0, 51);
            cycle(st, v, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
